wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_pkg.sv | 50 +++++
 rtl/wb_alu_fifo.sv | 68 ++++++
 rtl/wb_arbiter.sv | 148 ++++++++++++++
 tb/tb_wb_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the register-file write-back arbiter slice:
//   - datapath widths and the default ALU result buffer depth
//   - load funct3 encodings (RV32I LB/LH/LW/LBU/LHU)
//   - ALU buffer entry type and the write-back source selector
//   - small decode helpers for illegal / misaligned loads
// -----------------------------------------------------------------------------
package wb_pkg;

   localparam int DATA_W             = 32;
   localparam int RD_W               = 5;
   localparam int ALU_FIFO_DEPTH_DEF = 2;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;

   typedef struct packed {
      logic [RD_W-1:0]   rd;
      logic [DATA_W-1:0] data;
   } aluEntry_t;

   typedef enum logic [1:0] {
      SEL_NONE   = 2'd0,
      SEL_LOAD   = 2'd1,
      SEL_FIFO   = 2'd2,
      SEL_BYPASS = 2'd3
   } selSrc_e;

   // funct3 values 3, 6 and 7 are not load encodings.
   function automatic logic isIllegalF3(input logic [2:0] funct3);
      return (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
   endfunction

   // Halfwords need an even address, words a word-aligned address.
   function automatic logic isMisaligned(input logic [2:0] funct3,
                                         input logic [1:0] addrLo);
      logic mis;
      mis = 1'b0;
      if ((funct3 == F3_LH) || (funct3 == F3_LHU))
         mis = addrLo[0];
      else if (funct3 == F3_LW)
         mis = (addrLo != 2'd0);
      return mis;
   endfunction

endpackage

// File: rtl/wb_alu_fifo.sv
// -----------------------------------------------------------------------------
// wb_alu_fifo
// Small in-order buffer for ALU results that lost arbitration.
// Ports:
//   iClk, iRstN   clock, asynchronous active-low reset (pointers/count only)
//   iPush, iEntry write an entry (ignored when full unless popping same cycle)
//   iPop          retire the head entry (ignored when empty)
//   oHead         current head entry
//   oFull, oEmpty occupancy flags derived from the entry count
// -----------------------------------------------------------------------------
module wb_alu_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = ALU_FIFO_DEPTH_DEF
) (
   input  logic      iClk,
   input  logic      iRstN,
   input  logic      iPush,
   input  aluEntry_t iEntry,
   input  logic      iPop,
   output aluEntry_t oHead,
   output logic      oFull,
   output logic      oEmpty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   aluEntry_t        mem [DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic [CNT_W-1:0] count;
   logic             doPush;
   logic             doPop;

   assign oFull  = (count == CNT_W'(DEPTH));
   assign oEmpty = (count == '0);
   assign doPop  = iPop && !oEmpty;
   // A full buffer can still accept when the head leaves in the same cycle.
   assign doPush = iPush && (!oFull || doPop);
   assign oHead  = mem[rdPtr];

   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
   endfunction

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= nextPtr(wrPtr);
         if (doPop)  rdPtr <= nextPtr(rdPtr);
         case ({doPush, doPop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries data only; stale contents are unreachable after reset.
   always_ff @(posedge iClk) begin
      if (doPush) mem[wrPtr] <= iEntry;
   end

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Register-file write-back arbiter between a load unit (no backpressure) and
// an ALU (valid/ready). Loads win, buffered ALU results come next, and a fresh
// ALU result bypasses only when nothing else competes. Load data is extracted
// and sign/zero-extended here; misaligned or illegal loads are dropped with a
// one-cycle status pulse.
// Ports:
//   iClk, iRstN                     clock, asynchronous active-low reset
//   iAluValid/oAluReady/iAluRd/iAluData   ALU result handshake
//   iLdValid/iLdRd/iLdData/iLdFunct3/iLdAddrLo   load response
//   oWriteEn/oRdAddr/oWriteData     registered register-file write port
//   oMisalign, oIllegal             registered one-cycle fault pulses
// -----------------------------------------------------------------------------
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int ALU_FIFO_DEPTH = ALU_FIFO_DEPTH_DEF
) (
   input  logic              iClk,
   input  logic              iRstN,
   input  logic              iAluValid,
   output logic              oAluReady,
   input  logic [RD_W-1:0]   iAluRd,
   input  logic [DATA_W-1:0] iAluData,
   input  logic              iLdValid,
   input  logic [RD_W-1:0]   iLdRd,
   input  logic [DATA_W-1:0] iLdData,
   input  logic [2:0]        iLdFunct3,
   input  logic [1:0]        iLdAddrLo,
   output logic              oWriteEn,
   output logic [RD_W-1:0]   oRdAddr,
   output logic [DATA_W-1:0] oWriteData,
   output logic              oMisalign,
   output logic              oIllegal
);

   aluEntry_t         fifoHead;
   aluEntry_t         aluEntry;
   logic              fifoFull;
   logic              fifoEmpty;
   logic              fifoPop;
   logic              fifoPush;
   logic              aluAccept;
   selSrc_e           sel_p0;
   logic              writeEn_p0;
   logic [RD_W-1:0]   rdAddr_p0;
   logic [DATA_W-1:0] writeData_p0;
   logic              misalign_p0;
   logic              illegal_p0;
   logic              ldIllegal;
   logic              ldMisalign;

   // Extract the addressed byte/halfword and extend it to a full word.
   function automatic logic [DATA_W-1:0] extendLoad(input logic [2:0]        funct3,
                                                    input logic [1:0]        addrLo,
                                                    input logic [DATA_W-1:0] word);
      logic signed [7:0]  byteS;
      logic signed [15:0] halfS;
      logic [DATA_W-1:0]  res;
      byteS = signed'(word[{addrLo, 3'b000} +: 8]);
      halfS = signed'(addrLo[1] ? word[31:16] : word[15:0]);
      case (funct3)
         F3_LB:   res = {{(DATA_W-8){byteS[7]}}, byteS};
         F3_LBU:  res = {{(DATA_W-8){1'b0}}, byteS};
         F3_LH:   res = {{(DATA_W-16){halfS[15]}}, halfS};
         F3_LHU:  res = {{(DATA_W-16){1'b0}}, halfS};
         default: res = word;
      endcase
      return res;
   endfunction

   assign aluEntry = '{rd: iAluRd, data: iAluData};

   // The head retires whenever no load claims the port, which is also what
   // lets a full buffer take a new ALU result in the same cycle.
   assign fifoPop   = !iLdValid && !fifoEmpty;
   assign oAluReady = !fifoFull || fifoPop;
   assign aluAccept = iAluValid && oAluReady;
   assign fifoPush  = aluAccept && !(fifoEmpty && !iLdValid);

   assign ldIllegal  = isIllegalF3(iLdFunct3);
   assign ldMisalign = !ldIllegal && isMisaligned(iLdFunct3, iLdAddrLo);

   wb_alu_fifo #(
      .DEPTH (ALU_FIFO_DEPTH)
   ) uFifo (
      .iClk   (iClk),
      .iRstN  (iRstN),
      .iPush  (fifoPush),
      .iEntry (aluEntry),
      .iPop   (fifoPop),
      .oHead  (fifoHead),
      .oFull  (fifoFull),
      .oEmpty (fifoEmpty)
   );

   // ---- stage p0: source selection and load extension ----
   always_comb begin
      sel_p0       = SEL_NONE;
      writeEn_p0   = 1'b0;
      rdAddr_p0    = '0;
      writeData_p0 = '0;
      misalign_p0  = 1'b0;
      illegal_p0   = 1'b0;
      if (iLdValid)            sel_p0 = SEL_LOAD;
      else if (!fifoEmpty)     sel_p0 = SEL_FIFO;
      else if (aluAccept)      sel_p0 = SEL_BYPASS;
      case (sel_p0)
         SEL_LOAD: begin
            illegal_p0   = ldIllegal;
            misalign_p0  = ldMisalign;
            rdAddr_p0    = iLdRd;
            writeData_p0 = extendLoad(iLdFunct3, iLdAddrLo, iLdData);
            writeEn_p0   = !ldIllegal && !ldMisalign && (iLdRd != '0);
         end
         SEL_FIFO: begin
            rdAddr_p0    = fifoHead.rd;
            writeData_p0 = fifoHead.data;
            writeEn_p0   = (fifoHead.rd != '0);
         end
         SEL_BYPASS: begin
            rdAddr_p0    = iAluRd;
            writeData_p0 = iAluData;
            writeEn_p0   = (iAluRd != '0);
         end
         default: ;
      endcase
   end

   // ---- stage p1: registered write port and status pulses ----
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         oWriteEn   <= 1'b0;
         oRdAddr    <= '0;
         oWriteData <= '0;
         oMisalign  <= 1'b0;
         oIllegal   <= 1'b0;
      end else begin
         oWriteEn   <= writeEn_p0;
         oRdAddr    <= rdAddr_p0;
         oWriteData <= writeData_p0;
         oMisalign  <= misalign_p0;
         oIllegal   <= illegal_p0;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
   localparam int DEPTH = 2;

   logic        iClk;
   logic        iRstN;
   logic        iAluValid;
   logic        oAluReady;
   logic [4:0]  iAluRd;
   logic [31:0] iAluData;
   logic        iLdValid;
   logic [4:0]  iLdRd;
   logic [31:0] iLdData;
   logic [2:0]  iLdFunct3;
   logic [1:0]  iLdAddrLo;
   logic        oWriteEn;
   logic [4:0]  oRdAddr;
   logic [31:0] oWriteData;
   logic        oMisalign;
   logic        oIllegal;

   wb_arbiter #(.ALU_FIFO_DEPTH(DEPTH)) dut (
      .iClk       (iClk),
      .iRstN      (iRstN),
      .iAluValid  (iAluValid),
      .oAluReady  (oAluReady),
      .iAluRd     (iAluRd),
      .iAluData   (iAluData),
      .iLdValid   (iLdValid),
      .iLdRd      (iLdRd),
      .iLdData    (iLdData),
      .iLdFunct3  (iLdFunct3),
      .iLdAddrLo  (iLdAddrLo),
      .oWriteEn   (oWriteEn),
      .oRdAddr    (oRdAddr),
      .oWriteData (oWriteData),
      .oMisalign  (oMisalign),
      .oIllegal   (oIllegal)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   typedef struct packed {
      logic        wen;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        mis;
      logic        ill;
   } exp_t;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   typedef struct packed {
      logic [2:0]  f3;
      logic [1:0]  lo;
      logic [31:0] word;
      logic [31:0] expData;
      logic        mis;
      logic        ill;
   } vec_t;

   exp_t sbQ[$];
   ent_t mFifo[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkBit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Compare the registered outputs against the oldest pending expectation.
   task automatic compareOut();
      exp_t e;
      if (sbQ.size() > 0) begin
         e = sbQ.pop_front();
         checkBit("writeEn", oWriteEn, e.wen);
         checkBit("misalign", oMisalign, e.mis);
         checkBit("illegal", oIllegal, e.ill);
         if (e.wen) begin
            check("rdAddr", {27'b0, oRdAddr}, {27'b0, e.rd});
            check("writeData", oWriteData, e.data);
         end
      end
   endtask

   // One cycle: check last cycle's result, drive new inputs, check ready,
   // and queue the expected write-back for the next cycle.
   task automatic stepCycle(input logic ldV, input logic [4:0] ldRd, input logic [31:0] ldData,
                            input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] expLd,
                            input logic expMis, input logic expIll,
                            input logic aluV, input logic [4:0] aluRd, input logic [31:0] aluData,
                            output logic accepted);
      exp_t e;
      ent_t h;
      logic pop;
      logic ready;
      logic acc;
      @(negedge iClk);
      compareOut();
      iLdValid  = ldV;
      iLdRd     = ldRd;
      iLdData   = ldData;
      iLdFunct3 = f3;
      iLdAddrLo = lo;
      iAluValid = aluV;
      iAluRd    = aluRd;
      iAluData  = aluData;
      #1;
      pop   = !ldV && (mFifo.size() > 0);
      ready = (mFifo.size() < DEPTH) || pop;
      checkBit("aluReady", oAluReady, ready);
      acc = aluV && ready;
      e = '0;
      if (ldV) begin
         e.mis  = expMis;
         e.ill  = expIll;
         e.wen  = !expMis && !expIll && (ldRd != 5'd0);
         e.rd   = ldRd;
         e.data = expLd;
      end else if (pop) begin
         h      = mFifo.pop_front();
         e.wen  = (h.rd != 5'd0);
         e.rd   = h.rd;
         e.data = h.data;
      end else if (acc) begin
         e.wen  = (aluRd != 5'd0);
         e.rd   = aluRd;
         e.data = aluData;
      end
      if (acc && (ldV || pop)) mFifo.push_back('{rd: aluRd, data: aluData});
      sbQ.push_back(e);
      accepted = acc;
   endtask

   task automatic idle();
      logic a;
      stepCycle(1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, a);
   endtask

   task automatic aluOnly(input logic [4:0] rd, input logic [31:0] data);
      logic a;
      stepCycle(1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b1, rd, data, a);
   endtask

   vec_t vecs[17];
   logic acc;
   int   k;
   int   guard;

   initial begin
      vecs = '{
         '{3'd0, 2'd0, 32'h8001ABCD, 32'hFFFFFFCD, 1'b0, 1'b0},
         '{3'd0, 2'd1, 32'h8001ABCD, 32'hFFFFFFAB, 1'b0, 1'b0},
         '{3'd0, 2'd2, 32'h8001ABCD, 32'h00000001, 1'b0, 1'b0},
         '{3'd4, 2'd3, 32'h8001ABCD, 32'h00000080, 1'b0, 1'b0},
         '{3'd0, 2'd3, 32'h8001ABCD, 32'hFFFFFF80, 1'b0, 1'b0},
         '{3'd1, 2'd0, 32'h8001ABCD, 32'hFFFFABCD, 1'b0, 1'b0},
         '{3'd5, 2'd0, 32'h8001ABCD, 32'h0000ABCD, 1'b0, 1'b0},
         '{3'd5, 2'd2, 32'h8001ABCD, 32'h00008001, 1'b0, 1'b0},
         '{3'd1, 2'd2, 32'h8001ABCD, 32'hFFFF8001, 1'b0, 1'b0},
         '{3'd2, 2'd0, 32'h8001ABCD, 32'h8001ABCD, 1'b0, 1'b0},
         '{3'd2, 2'd2, 32'h8001ABCD, 32'h00000000, 1'b1, 1'b0},
         '{3'd2, 2'd1, 32'h8001ABCD, 32'h00000000, 1'b1, 1'b0},
         '{3'd1, 2'd1, 32'h8001ABCD, 32'h00000000, 1'b1, 1'b0},
         '{3'd5, 2'd3, 32'h8001ABCD, 32'h00000000, 1'b1, 1'b0},
         '{3'd3, 2'd0, 32'h8001ABCD, 32'h00000000, 1'b0, 1'b1},
         '{3'd6, 2'd1, 32'h8001ABCD, 32'h00000000, 1'b0, 1'b1},
         '{3'd7, 2'd2, 32'h8001ABCD, 32'h00000000, 1'b0, 1'b1}
      };

      iLdValid = 0; iLdRd = 0; iLdData = 0; iLdFunct3 = 0; iLdAddrLo = 0;
      iAluValid = 0; iAluRd = 0; iAluData = 0;
      iRstN = 1'b1;
      #1 iRstN = 1'b0;
      #1;
      checkBit("rstWriteEn", oWriteEn, 1'b0);
      check("rstRdAddr", {27'b0, oRdAddr}, 32'd0);
      check("rstWriteData", oWriteData, 32'd0);
      checkBit("rstMisalign", oMisalign, 1'b0);
      checkBit("rstIllegal", oIllegal, 1'b0);
      repeat (2) @(posedge iClk);
      @(negedge iClk);
      iRstN = 1'b1;
      #1 checkBit("rstReady", oAluReady, 1'b1);

      // Load extension / fault table.
      for (int i = 0; i < 17; i++)
         stepCycle(1'b1, 5'(i + 10), vecs[i].word, vecs[i].f3, vecs[i].lo, vecs[i].expData,
                   vecs[i].mis, vecs[i].ill, 1'b0, 5'd0, 32'd0, acc);
      idle();

      // ALU only on empty buffer.
      aluOnly(5'd5, 32'h1234);
      idle();

      // Load/ALU collision: load first, ALU one cycle later.
      stepCycle(1'b1, 5'd3, 32'h000000F0, 3'd0, 2'd0, 32'hFFFFFFF0, 1'b0, 1'b0,
                1'b1, 5'd7, 32'd9, acc);
      idle();
      idle();

      // Backpressure: four loads with the ALU offering every cycle.
      k = 0;
      for (int i = 0; i < 4; i++) begin
         stepCycle(1'b1, 5'(i + 1), 32'h100 + i, 3'd2, 2'd0, 32'h100 + i, 1'b0, 1'b0,
                   1'b1, 5'(20 + k), 32'hA0 + k, acc);
         if (i >= 2) checkBit("bpReadyLow", oAluReady, 1'b0);
         if (acc) k++;
      end
      guard = 0;
      while (k < 6 && guard < 20) begin
         stepCycle(1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 32'd0, 1'b0, 1'b0,
                   1'b1, 5'(20 + k), 32'hA0 + k, acc);
         if (acc) k++;
         guard++;
      end
      checkBit("bpDrained", (k == 6), 1'b1);
      repeat (3) idle();

      // Faults and x0.
      stepCycle(1'b1, 5'd9, 32'hCAFEBABE, 3'd2, 2'd2, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, acc);
      stepCycle(1'b1, 5'd9, 32'hCAFEBABE, 3'd3, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, acc);
      aluOnly(5'd0, 32'hDEAD);
      stepCycle(1'b1, 5'd0, 32'h11223344, 3'd2, 2'd0, 32'h11223344, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, acc);
      idle();

      // Reset with two buffered ALU results.
      stepCycle(1'b1, 5'd1, 32'h55, 3'd2, 2'd0, 32'h55, 1'b0, 1'b0, 1'b1, 5'd30, 32'h77, acc);
      stepCycle(1'b1, 5'd2, 32'h66, 3'd2, 2'd0, 32'h66, 1'b0, 1'b0, 1'b1, 5'd31, 32'h88, acc);
      @(negedge iClk);
      compareOut();
      #2;
      iLdValid = 1'b0;
      iAluValid = 1'b0;
      iRstN = 1'b0;
      #1;
      checkBit("midRstWriteEn", oWriteEn, 1'b0);
      check("midRstRdAddr", {27'b0, oRdAddr}, 32'd0);
      check("midRstWriteData", oWriteData, 32'd0);
      sbQ.delete();
      mFifo.delete();
      @(posedge iClk);
      @(negedge iClk);
      iRstN = 1'b1;
      #1 checkBit("midRstReady", oAluReady, 1'b1);
      repeat (3) idle();
      aluOnly(5'd12, 32'hABCD0123);
      idle();

      @(negedge iClk);
      compareOut();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
